hack_uart_rom_loader: RTL and testbench

- Downstream consumer of the UART receiver/FIFO: drains received bytes over the FIFO read-strobe interface and assembles them into 16-bit Hack instructions.
- Writes the instructions sequentially into instruction ROM starting at address 0.
- Holds the Hack CPU in reset while loading; releases it on successful completion.
- Host protocol: 2-byte big-endian word count N, then N words as 2 bytes each, big-endian (high byte first).

---
 rtl/hack_uart_rom_loader.sv | 188 ++++++++++++++++++
 tb/tb_hack_uart_rom_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_uart_rom_loader.sv
// hack_uart_rom_loader: drains bytes from a UART receive FIFO and programs the Hack instruction
// ROM. The host sends a 16-bit big-endian word count N, then N big-endian 16-bit words. The words
// are written to ROM from address 0 upwards. The CPU is held in reset until the load completes.
//
// Optional feature macro: HACK_LOADER_CHECKSUM_EN. When it is defined, one trailing byte is
// expected after the last word (or after the header when N = 0). That byte must equal the XOR of
// all header and payload bytes, or the load ends in ERROR.
//
// Ports:
//   i_CLK, i_RESET_n    clock; asynchronous active-low reset
//   i_UART_Empty        FIFO empty flag
//   i_Data              FIFO read data, valid the cycle after o_Read_EN
//   i_Load_Req          restart request, honoured only in DONE or ERROR
//   o_Read_EN           one-cycle FIFO read strobe
//   o_ROM_WE            one-cycle ROM write enable
//   o_ROM_Addr          ROM write address
//   o_ROM_Data          ROM write data
//   o_CPU_Reset         1 = CPU held in reset
//   o_Done / o_Error    load finished successfully / load aborted
module hack_uart_rom_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned ROM_DEPTH = 32768,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_n,
  input  logic                 i_UART_Empty,
  input  logic [DATA_BITS-1:0] i_Data,
  input  logic                 i_Load_Req,
  output logic                 o_Read_EN,
  output logic                 o_ROM_WE,
  output logic [ADDR_W-1:0]    o_ROM_Addr,
  output logic [15:0]          o_ROM_Data,
  output logic                 o_CPU_Reset,
  output logic                 o_Done,
  output logic                 o_Error
);

`ifdef HACK_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StHdrHi, StHdrLo, StWordHi, StWordLo, StWrite, StDone, StError, StChk
  } state_e;
  localparam state_e StLoaded = StChk;
`else
  typedef enum logic [2:0] {
    StHdrHi, StHdrLo, StWordHi, StWordLo, StWrite, StDone, StError
  } state_e;
  localparam state_e StLoaded = StDone;
`endif

  localparam logic [16:0] DepthW = 17'(ROM_DEPTH);

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic                pend_q, pend_d;   // a strobe was issued last cycle; i_Data valid now
  logic                run_q;            // keeps the strobe low while in / just out of reset
  logic                byte_state;
  logic                read_en;
  logic [7:0]          byte_in;
  logic [15:0]         n_full;
  logic [15:0]         cnt_inc;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign byte_in = i_Data[7:0];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    n_full   = {n_q[15:8], byte_in};
    cnt_inc  = cnt_q + 16'd1;
`ifdef HACK_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    byte_state = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StWordHi) ||
                 (state_q == StWordLo) || (state_q == StChk);
`else
    byte_state = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StWordHi) ||
                 (state_q == StWordLo);
`endif
    // Strobe only when data is available and the previous strobe's byte is not being captured.
    read_en = run_q && byte_state && !i_UART_Empty && !pend_q;
    pend_d  = read_en;

`ifdef HACK_LOADER_CHECKSUM_EN
    if (pend_q && (state_q != StChk)) begin
      csum_d = csum_q ^ byte_in;
    end
`endif

    unique case (state_q)
      StHdrHi: begin
        if (pend_q) begin
          n_d[15:8] = byte_in;
          state_d   = StHdrLo;
        end
      end
      StHdrLo: begin
        if (pend_q) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
            state_d = StLoaded;
          end else if ({1'b0, n_full} > DepthW) begin
            state_d = StError;
          end else begin
            state_d = StWordHi;
          end
        end
      end
      StWordHi: begin
        if (pend_q) begin
          data_d[15:8] = byte_in;
          state_d      = StWordLo;
        end
      end
      StWordLo: begin
        if (pend_q) begin
          data_d[7:0] = byte_in;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        // The last increment may wrap the address to 0 when N equals the full ROM depth.
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == n_q) ? StLoaded : StWordHi;
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      StChk: begin
        if (pend_q) begin
          state_d = (byte_in == csum_q) ? StDone : StError;
        end
      end
`endif
      StDone, StError: begin
        if (i_Load_Req) begin
          state_d = StHdrHi;
          addr_d  = '0;
          cnt_d   = '0;
`ifdef HACK_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q <= StHdrHi;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      run_q   <= 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign o_Read_EN   = read_en;
  assign o_ROM_WE    = (state_q == StWrite);
  assign o_ROM_Addr  = addr_q;
  assign o_ROM_Data  = data_q;
  assign o_CPU_Reset = (state_q != StDone);
  assign o_Done      = (state_q == StDone);
  assign o_Error     = (state_q == StError);

endmodule

// File: tb/tb_hack_uart_rom_loader.sv
// Directed bench for hack_uart_rom_loader: a small FIFO model feeds bytes, monitors log read
// strobes and ROM writes, and each test task compares the outcome against hand-computed values.
module tb_hack_uart_rom_loader;

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam int unsigned Extra = 1;
`else
  localparam int unsigned Extra = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_empty;
  logic [7:0]  uart_data = 8'h00;
  logic        load_req = 1'b0;
  logic        rd_en, rom_we, cpu_rst, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;

  always #5 clk = ~clk;

  hack_uart_rom_loader #(
    .ADDR_W(15), .ROM_DEPTH(32768), .DATA_BITS(8)
  ) dut (
    .i_CLK        (clk),
    .i_RESET_n    (rst_n),
    .i_UART_Empty (uart_empty),
    .i_Data       (uart_data),
    .i_Load_Req   (load_req),
    .o_Read_EN    (rd_en),
    .o_ROM_WE     (rom_we),
    .o_ROM_Addr   (rom_addr),
    .o_ROM_Data   (rom_data),
    .o_CPU_Reset  (cpu_rst),
    .o_Done       (done),
    .o_Error      (error)
  );

  // FIFO model: data appears the cycle after the strobe.
  logic [7:0]  fifo_mem [0:255];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        flush = 1'b0;
  assign uart_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en) begin
      uart_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitors: strobe count, protocol violations, ROM write log.
  int unsigned rd_cnt = 0;
  int unsigned we_cnt = 0;
  int unsigned rule_viol = 0;
  logic        rd_prev = 1'b0;
  logic [14:0] we_addr [0:63];
  logic [15:0] we_data [0:63];

  always @(posedge clk) begin
    rd_prev <= rd_en;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en && (rd_prev || uart_empty)) rule_viol <= rule_viol + 1;
    if (rom_we) begin
      we_addr[we_cnt[5:0]] <= rom_addr;
      we_data[we_cnt[5:0]] <= rom_data;
      we_cnt <= we_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_end(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_load_req();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_read_en: got %b want 0", rd_en); end
    vectors++; if (rom_we !== 1'b0) begin miscompares++; $display("FAIL rst_rom_we: got %b want 0", rom_we); end
    vectors++; if (rom_addr !== 15'd0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", rom_addr); end
    vectors++; if (rom_data !== 16'd0) begin miscompares++; $display("FAIL rst_data: got %h want 0", rom_data); end
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_rst); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b want 0", error); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    vectors++; if (rd_cnt !== 0) begin miscompares++; $display("FAIL idle_reads: got %0d want 0", rd_cnt); end
    vectors++; if (we_cnt !== 0) begin miscompares++; $display("FAIL idle_writes: got %0d want 0", we_cnt); end
    vectors++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL idle_status: cpu_rst %b done %b want 1 0", cpu_rst, done);
    end
  endtask

  task automatic test_two_words();
    int unsigned brd = rd_cnt;
    int unsigned bwe = we_cnt;
    int unsigned i1 = bwe + 1;
    logic ok;
    push(8'h00); push(8'h02); push(8'h12); push(8'h34); push(8'hAB); push(8'hCD);
    if (Extra != 0) push(8'h42);
    wait_end(300, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL two_timeout: got no end want done"); end
    vectors++; if (done !== 1'b1 || error !== 1'b0) begin
      miscompares++; $display("FAIL two_status: done %b error %b want 1 0", done, error);
    end
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL two_cpu_reset: got %b want 0", cpu_rst); end
    vectors++; if (we_cnt - bwe !== 2) begin miscompares++; $display("FAIL two_writes: got %0d want 2", we_cnt - bwe); end
    vectors++; if (we_addr[bwe[5:0]] !== 15'd0 || we_data[bwe[5:0]] !== 16'h1234) begin
      miscompares++; $display("FAIL two_w0: got %h=%h want 0000=1234", we_addr[bwe[5:0]], we_data[bwe[5:0]]);
    end
    vectors++; if (we_addr[i1[5:0]] !== 15'd1 || we_data[i1[5:0]] !== 16'hABCD) begin
      miscompares++; $display("FAIL two_w1: got %h=%h want 0001=abcd", we_addr[i1[5:0]], we_data[i1[5:0]]);
    end
    vectors++; if (rd_cnt - brd !== 6 + Extra) begin
      miscompares++; $display("FAIL two_reads: got %0d want %0d", rd_cnt - brd, 6 + Extra);
    end
    vectors++; if (rom_addr !== 15'd2) begin miscompares++; $display("FAIL two_final_addr: got %h want 2", rom_addr); end
    pulse_load_req();
    vectors++; if (done !== 1'b0 || cpu_rst !== 1'b1 || rom_addr !== 15'd0) begin
      miscompares++; $display("FAIL two_reload: done %b cpu_rst %b addr %h want 0 1 0", done, cpu_rst, rom_addr);
    end
  endtask

  task automatic test_zero_words();
    int unsigned brd = rd_cnt;
    int unsigned bwe = we_cnt;
    logic ok;
    push(8'h00); push(8'h00);
    if (Extra != 0) push(8'h00);
    wait_end(100, ok);
    vectors++; if (!ok || done !== 1'b1 || cpu_rst !== 1'b0) begin
      miscompares++; $display("FAIL zero_status: done %b cpu_rst %b want 1 0", done, cpu_rst);
    end
    vectors++; if (we_cnt - bwe !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", we_cnt - bwe); end
    vectors++; if (rd_cnt - brd !== 2 + Extra) begin
      miscompares++; $display("FAIL zero_reads: got %0d want %0d", rd_cnt - brd, 2 + Extra);
    end
    pulse_load_req();
  endtask

  task automatic test_oversize();
    int unsigned brd = rd_cnt;
    int unsigned bwe = we_cnt;
    logic ok;
    push(8'h80); push(8'h01); push(8'h55);
    wait_end(100, ok);
    vectors++; if (!ok || error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL big_status: error %b cpu_rst %b done %b want 1 1 0", error, cpu_rst, done);
    end
    repeat (10) @(negedge clk);
    vectors++; if (rd_cnt - brd !== 2) begin miscompares++; $display("FAIL big_reads: got %0d want 2", rd_cnt - brd); end
    vectors++; if (we_cnt - bwe !== 0) begin miscompares++; $display("FAIL big_writes: got %0d want 0", we_cnt - bwe); end
    do_flush();
    pulse_load_req();
    vectors++; if (error !== 1'b0 || cpu_rst !== 1'b1) begin
      miscompares++; $display("FAIL big_reload: error %b cpu_rst %b want 0 1", error, cpu_rst);
    end
  endtask

  // N equal to the full ROM depth is legal: the loader must wait for payload, not flag an error.
  task automatic test_depth_boundary();
    int unsigned brd = rd_cnt;
    push(8'h80); push(8'h00);
    repeat (12) @(negedge clk);
    vectors++; if (error !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      miscompares++; $display("FAIL depth_status: error %b done %b cpu_rst %b want 0 0 1", error, done, cpu_rst);
    end
    vectors++; if (rd_cnt - brd !== 2) begin miscompares++; $display("FAIL depth_reads: got %0d want 2", rd_cnt - brd); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midload();
    int unsigned brd = rd_cnt;
    int unsigned bwe;
    logic ok = 1'b0;
    push(8'h00); push(8'h02); push(8'h12); push(8'h34); push(8'hAB); push(8'hCD);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_cnt - brd >= 3) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL mid_timeout: got <3 reads want 3"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (rd_en !== 1'b0 || rom_we !== 1'b0 || rom_addr !== 15'd0 || rom_data !== 16'd0) begin
      miscompares++; $display("FAIL mid_rst_bus: rd %b we %b addr %h data %h want 0 0 0 0", rd_en, rom_we, rom_addr, rom_data);
    end
    vectors++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_status: cpu_rst %b done %b error %b want 1 0 0", cpu_rst, done, error);
    end
    do_flush();
    rst_n = 1'b1;
    @(negedge clk);
    brd = rd_cnt;
    bwe = we_cnt;
    push(8'h00); push(8'h01); push(8'hBE); push(8'hEF);
    if (Extra != 0) push(8'h50);
    wait_end(200, ok);
    vectors++; if (!ok || done !== 1'b1) begin miscompares++; $display("FAIL mid_reload_done: got %b want 1", done); end
    vectors++; if (we_cnt - bwe !== 1 || we_addr[bwe[5:0]] !== 15'd0 || we_data[bwe[5:0]] !== 16'hBEEF) begin
      miscompares++; $display("FAIL mid_reload_write: n %0d %h=%h want 1 0000=beef", we_cnt - bwe, we_addr[bwe[5:0]], we_data[bwe[5:0]]);
    end
    vectors++; if (rd_cnt - brd !== 4 + Extra) begin
      miscompares++; $display("FAIL mid_reload_reads: got %0d want %0d", rd_cnt - brd, 4 + Extra);
    end
    pulse_load_req();
  endtask

`ifdef HACK_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int unsigned bwe = we_cnt;
    logic ok;
    push(8'h00); push(8'h01); push(8'h00); push(8'h10); push(8'hFF);
    wait_end(200, ok);
    vectors++; if (!ok || error !== 1'b1 || cpu_rst !== 1'b1) begin
      miscompares++; $display("FAIL chk_bad: error %b cpu_rst %b want 1 1", error, cpu_rst);
    end
    vectors++; if (we_cnt - bwe !== 1 || we_data[bwe[5:0]] !== 16'h0010) begin
      miscompares++; $display("FAIL chk_write: n %0d data %h want 1 0010", we_cnt - bwe, we_data[bwe[5:0]]);
    end
    pulse_load_req();
    vectors++; if (error !== 1'b0 || rom_addr !== 15'd0) begin
      miscompares++; $display("FAIL chk_reload: error %b addr %h want 0 0", error, rom_addr);
    end
    push(8'h00); push(8'h01); push(8'h00); push(8'h10); push(8'h11);
    wait_end(200, ok);
    vectors++; if (!ok || done !== 1'b1) begin miscompares++; $display("FAIL chk_good: done %b want 1", done); end
    pulse_load_req();
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_words();
    test_oversize();
    test_depth_boundary();
    test_reset_midload();
`ifdef HACK_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    vectors++; if (rule_viol !== 0) begin
      miscompares++; $display("FAIL strobe_rules: got %0d violations want 0", rule_viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
